// File: rtl/ucore_seq_if.sv
// Control, load and status bundle of the ucore_seq microcode sequencer.
// The master drives control and load signals; the slave (the core) drives status.
interface ucore_seq_if #(
  parameter int PC_W  = 6,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int IMM_W = 8
);
  localparam int SEL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int IW    = 5 + SEL_W + IMM_W;

  logic             start;
  logic             stop;
  logic [IN_W-1:0]  cond_in;
  logic             ld_en;
  logic [PC_W-1:0]  ld_addr;
  logic [IW-1:0]    ld_data;
  logic [OUT_W-1:0] out_q;
  logic [PC_W-1:0]  pc;
  logic             busy;
  logic             halted;
  logic             fault;

  modport master (
    output start, stop, cond_in, ld_en, ld_addr, ld_data,
    input  out_q, pc, busy, halted, fault
  );

  modport slave (
    input  start, stop, cond_in, ld_en, ld_addr, ld_data,
    output out_q, pc, busy, halted, fault
  );
endinterface

// File: rtl/ucore_seq.sv
// Loadable microcode sequencer: executes one stored instruction per cycle with
// branches, wait-on-condition, a call/return stack and a loop counter.
module ucore_seq #(
  parameter int PC_W        = 6,
  parameter int IN_W        = 8,
  parameter int OUT_W       = 8,
  parameter int CNT_W       = 8,
  parameter int IMM_W       = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic        clk,
  input  logic        aresetn,
  ucore_seq_if.slave  bus
);
  localparam int SEL_W = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam int IW    = 5 + SEL_W + IMM_W;
  localparam int DEPTH = 2 ** PC_W;
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int SA_W  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_OUT  = 4'd1,
    OP_JMP  = 4'd2,
    OP_BR   = 4'd3,
    OP_WAIT = 4'd4,
    OP_CALL = 4'd5,
    OP_RET  = 4'd6,
    OP_LDC  = 4'd7,
    OP_DJNZ = 4'd8,
    OP_HALT = 4'd9
  } opcode_e;

  logic [IW-1:0]    mem_q [DEPTH];

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SP_W-1:0]  sp_q, sp_d;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic [PC_W-1:0]  stack_d [STACK_DEPTH];
  logic [OUT_W-1:0] out_q, out_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             fault_q, fault_d;

  logic [IW-1:0]    instr;
  logic [3:0]       opc;
  logic             pol;
  logic [SEL_W-1:0] sel;
  logic [IMM_W-1:0] imm;
  logic             cond_bit;
  logic             cond_ok;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  imm_pc;
  logic [CNT_W-1:0] cnt_dec;
  logic [SP_W-1:0]  sp_dec;
  logic             stack_full;
  logic             stack_empty;

  assign instr              = mem_q[pc_q];
  assign {opc, pol, sel, imm} = instr;
  assign pc_inc             = pc_q + PC_W'(1);
  assign imm_pc             = imm[PC_W-1:0];
  assign cnt_dec            = cnt_q - CNT_W'(1);
  assign sp_dec             = sp_q - SP_W'(1);
  assign stack_full         = (sp_q == SP_W'(STACK_DEPTH));
  assign stack_empty        = (sp_q == '0);

  // Selector values beyond the last condition input read as 0.
  always_comb begin
    cond_bit = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (sel == SEL_W'(i)) cond_bit = bus.cond_in[i];
    end
  end

  assign cond_ok = (cond_bit == pol);

  // The store has no reset; writes are blocked only while a program runs.
  always_ff @(posedge clk) begin
    if (bus.ld_en && (state_q != ST_RUN)) begin
      mem_q[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    out_d   = out_q;
    stack_d = stack_q;

    if (bus.stop) begin
      state_d = ST_IDLE;
      pc_d    = '0;
      cnt_d   = '0;
      sp_d    = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_HALT: begin
          if (bus.start) begin
            state_d = ST_RUN;
            pc_d    = '0;
            cnt_d   = '0;
            sp_d    = '0;
          end
        end
        ST_RUN: begin
          case (opc)
            OP_NOP:  pc_d = pc_inc;
            OP_OUT: begin
              out_d = imm[OUT_W-1:0];
              pc_d  = pc_inc;
            end
            OP_JMP:  pc_d = imm_pc;
            OP_BR:   pc_d = cond_ok ? imm_pc : pc_inc;
            OP_WAIT: pc_d = cond_ok ? pc_inc : pc_q;
            OP_CALL: begin
              if (stack_full) begin
                state_d = ST_FAULT;
              end else begin
                stack_d[sp_q[SA_W-1:0]] = pc_inc;
                sp_d = sp_q + SP_W'(1);
                pc_d = imm_pc;
              end
            end
            OP_RET: begin
              if (stack_empty) begin
                state_d = ST_FAULT;
              end else begin
                pc_d = stack_q[sp_dec[SA_W-1:0]];
                sp_d = sp_dec;
              end
            end
            OP_LDC: begin
              cnt_d = imm[CNT_W-1:0];
              pc_d  = pc_inc;
            end
            // Modular decrement: a zero counter wraps to all-ones and loops.
            OP_DJNZ: begin
              cnt_d = cnt_dec;
              pc_d  = (cnt_dec != '0) ? imm_pc : pc_inc;
            end
            OP_HALT: state_d = ST_HALT;
            default: state_d = ST_FAULT;
          endcase
        end
        default: state_d = state_q;
      endcase
    end

    busy_d   = (state_d == ST_RUN);
    halted_d = (state_d == ST_HALT);
    fault_d  = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      cnt_q    <= '0;
      sp_q     <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      sp_q     <= sp_d;
      out_q    <= out_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= stack_d[i];
    end
  end

  assign bus.out_q  = out_q;
  assign bus.pc     = pc_q;
  assign bus.busy   = busy_q;
  assign bus.halted = halted_q;
  assign bus.fault  = fault_q;
endmodule

// File: tb/tb_ucore_seq.sv
// Self-checking bench for ucore_seq: an instruction-level reference model is
// compared every cycle, plus directed programs with hand-derived expectations.
module tb_ucore_seq;
  logic clk = 1'b0;
  logic aresetn;

  always #5 clk = ~clk;

  ucore_seq_if #(.PC_W(6), .IN_W(8), .OUT_W(8), .IMM_W(8)) bus ();

  ucore_seq #(
    .PC_W(6), .IN_W(8), .OUT_W(8), .CNT_W(8), .IMM_W(8), .STACK_DEPTH(4)
  ) dut (
    .clk    (clk),
    .aresetn(aresetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: 0 idle, 1 run, 2 halt, 3 fault.
  int          m_state = 0;
  int          m_pc    = 0;
  int          m_cnt   = 0;
  int          m_out   = 0;
  int          m_stack[$];
  logic [15:0] m_mem [64];

  function automatic logic [15:0] mk(input int opc, input int pol, input int sel, input int imm);
    logic [3:0] o;
    logic       p;
    logic [2:0] s;
    logic [7:0] i;
    o = opc[3:0];
    p = pol[0];
    s = sel[2:0];
    i = imm[7:0];
    return {o, p, s, i};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    m_state = 0;
    m_pc    = 0;
    m_cnt   = 0;
    m_out   = 0;
    m_stack.delete();
  endtask

  task automatic modelStep();
    logic [15:0] ins;
    int opc, pol, sel, imm, c, nxt, pre;
    pre = m_state;
    ins = m_mem[m_pc];
    opc = int'(ins[15:12]);
    pol = int'(ins[11]);
    sel = int'(ins[10:8]);
    imm = int'(ins[7:0]);
    c   = (((int'(bus.cond_in) >> sel) & 1) == pol) ? 1 : 0;
    nxt = (m_pc + 1) % 64;
    if (bus.stop) begin
      m_state = 0;
      m_pc    = 0;
      m_cnt   = 0;
      m_stack.delete();
    end else if ((m_state == 0 || m_state == 2) && bus.start) begin
      m_state = 1;
      m_pc    = 0;
      m_cnt   = 0;
      m_stack.delete();
    end else if (m_state == 1) begin
      case (opc)
        0: m_pc = nxt;
        1: begin m_out = imm; m_pc = nxt; end
        2: m_pc = imm % 64;
        3: m_pc = c ? imm % 64 : nxt;
        4: if (c) m_pc = nxt;
        5: begin
          if (m_stack.size() == 4) m_state = 3;
          else begin m_stack.push_back(nxt); m_pc = imm % 64; end
        end
        6: begin
          if (m_stack.size() == 0) m_state = 3;
          else m_pc = m_stack.pop_back();
        end
        7: begin m_cnt = imm; m_pc = nxt; end
        8: begin
          m_cnt = (m_cnt + 255) % 256;
          m_pc  = (m_cnt != 0) ? imm % 64 : nxt;
        end
        9: m_state = 2;
        default: m_state = 3;
      endcase
    end
    if (bus.ld_en && pre != 1) m_mem[bus.ld_addr] = bus.ld_data;
  endtask

  always @(posedge clk) begin
    if (!aresetn) modelReset();
    else modelStep();
    #1;
    checkOutput("cyc_pc",     32'(bus.pc),     32'(m_pc));
    checkOutput("cyc_out",    32'(bus.out_q),  32'(m_out));
    checkOutput("cyc_busy",   32'(bus.busy),   32'(m_state == 1));
    checkOutput("cyc_halted", 32'(bus.halted), 32'(m_state == 2));
    checkOutput("cyc_fault",  32'(bus.fault),  32'(m_state == 3));
  end

  task automatic applyStimulus(input logic st, input logic sp, input logic ld,
                               input logic [5:0] addr, input logic [15:0] data,
                               input logic [7:0] cond);
    bus.start   = st;
    bus.stop    = sp;
    bus.ld_en   = ld;
    bus.ld_addr = addr;
    bus.ld_data = data;
    bus.cond_in = cond;
  endtask

  task automatic loadWord(input int a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b0, 1'b1, a[5:0], d, bus.cond_in);
    @(negedge clk);
    bus.ld_en = 1'b0;
  endtask

  task automatic startRun();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulseStop();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic runCount(input int limit, inout int cyc);
    while (bus.halted !== 1'b1 && bus.fault !== 1'b1 && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= limit) begin
      checks++;
      errors++;
      $display("[TB] FAIL run_timeout got %0d cycles limit %0d", cyc, limit);
    end
  endtask

  function automatic logic [15:0] randWord();
    int opc;
    opc = $urandom_range(0, 9);
    if ($urandom_range(0, 99) < 4) opc = $urandom_range(10, 15);
    if (opc == 9 && $urandom_range(0, 1) == 1) opc = 0;
    return mk(opc, $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 255));
  endfunction

  initial begin
    int cyc;
    aresetn = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 8'd0);
    repeat (2) @(negedge clk);
    checkOutput("reset_pc",   32'(bus.pc),    32'd0);
    checkOutput("reset_out",  32'(bus.out_q), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy),  32'd0);
    aresetn = 1'b1;
    for (int a = 0; a < 64; a++) loadWord(a, mk(9, 0, 0, 0));

    // Counted loop: LDC 3; OUT A5; DJNZ 1; HALT
    loadWord(0, mk(7, 0, 0, 3));
    loadWord(1, mk(1, 0, 0, 8'hA5));
    loadWord(2, mk(8, 0, 0, 1));
    loadWord(3, mk(9, 0, 0, 0));
    startRun();
    checkOutput("start_busy", 32'(bus.busy), 32'd1);
    repeat (2) @(negedge clk);
    checkOutput("out_after_c2", 32'(bus.out_q), 32'hA5);
    cyc = 2;
    runCount(40, cyc);
    checkOutput("loop_cycles", 32'(cyc), 32'd8);
    checkOutput("loop_pc", 32'(bus.pc), 32'd3);
    checkOutput("loop_halted", 32'(bus.halted), 32'd1);

    // stop and start together from HALT: stop wins, out_q is held
    applyStimulus(1'b1, 1'b1, 1'b0, 6'd0, 16'd0, 8'd0);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 8'd0);
    checkOutput("ss_busy", 32'(bus.busy), 32'd0);
    checkOutput("ss_halted", 32'(bus.halted), 32'd0);
    checkOutput("ss_pc", 32'(bus.pc), 32'd0);
    checkOutput("ss_out", 32'(bus.out_q), 32'hA5);

    // WAIT on cond_in[2]==1
    loadWord(0, mk(4, 1, 2, 0));
    loadWord(1, mk(9, 0, 0, 0));
    startRun();
    for (int k = 1; k <= 5; k++) begin
      bus.cond_in = 8'($urandom) & 8'hFB;
      @(negedge clk);
      checkOutput("wait_hold_pc", 32'(bus.pc), 32'd0);
    end
    bus.cond_in = 8'h04;
    @(negedge clk);
    checkOutput("wait_release_pc", 32'(bus.pc), 32'd1);
    bus.cond_in = 8'h00;
    pulseStop();

    // CALL nested one level too deep
    for (int k = 0; k < 5; k++) loadWord(k, mk(5, 0, 0, k + 1));
    startRun();
    repeat (5) @(negedge clk);
    checkOutput("ovf_fault", 32'(bus.fault), 32'd1);
    checkOutput("ovf_pc", 32'(bus.pc), 32'd4);
    repeat (2) @(negedge clk);
    checkOutput("ovf_frozen_pc", 32'(bus.pc), 32'd4);
    startRun();
    checkOutput("fault_ignores_start", 32'(bus.fault), 32'd1);
    pulseStop();
    checkOutput("stop_clears_fault", 32'(bus.fault), 32'd0);

    // RET with empty stack
    loadWord(0, mk(6, 0, 0, 0));
    startRun();
    @(negedge clk);
    checkOutput("ret_empty_fault", 32'(bus.fault), 32'd1);
    checkOutput("ret_empty_pc", 32'(bus.pc), 32'd0);
    pulseStop();

    // JMP with oversized immediate lands at 63, NOP there wraps to 0
    loadWord(0, mk(2, 0, 0, 8'hFF));
    loadWord(63, mk(0, 0, 0, 0));
    startRun();
    @(negedge clk);
    checkOutput("jmp_top_pc", 32'(bus.pc), 32'd63);
    @(negedge clk);
    checkOutput("wrap_pc", 32'(bus.pc), 32'd0);
    pulseStop();

    // DJNZ from cnt=0 wraps to 255 and loops 255 more times
    loadWord(0, mk(8, 0, 0, 2));
    loadWord(1, mk(9, 0, 0, 0));
    loadWord(2, mk(8, 0, 0, 2));
    loadWord(3, mk(9, 0, 0, 0));
    startRun();
    @(negedge clk);
    checkOutput("djnz0_pc", 32'(bus.pc), 32'd2);
    cyc = 1;
    runCount(400, cyc);
    checkOutput("djnz0_cycles", 32'(cyc), 32'd257);
    checkOutput("djnz0_end_pc", 32'(bus.pc), 32'd3);
    pulseStop();

    // ld_en during RUN must not change the store
    loadWord(0, mk(2, 0, 0, 0));
    startRun();
    applyStimulus(1'b0, 1'b0, 1'b1, 6'd0, mk(9, 0, 0, 0), 8'd0);
    @(negedge clk);
    bus.ld_en = 1'b0;
    repeat (2) @(negedge clk);
    pulseStop();
    startRun();
    repeat (3) @(negedge clk);
    checkOutput("ldrun_busy", 32'(bus.busy), 32'd1);
    checkOutput("ldrun_halted", 32'(bus.halted), 32'd0);
    checkOutput("ldrun_pc", 32'(bus.pc), 32'd0);
    pulseStop();

    // Asynchronous reset in the middle of a WAIT
    loadWord(0, mk(1, 0, 0, 8'h3C));
    loadWord(1, mk(4, 1, 2, 0));
    loadWord(2, mk(9, 0, 0, 0));
    startRun();
    repeat (3) @(negedge clk);
    checkOutput("pre_rst_out", 32'(bus.out_q), 32'h3C);
    checkOutput("pre_rst_pc", 32'(bus.pc), 32'd1);
    #2;
    aresetn = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_out", 32'(bus.out_q), 32'd0);
    checkOutput("rst_pc", 32'(bus.pc), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;
    bus.cond_in = 8'h04;
    repeat (3) @(negedge clk);
    checkOutput("post_rst_idle", 32'(bus.busy), 32'd0);
    checkOutput("post_rst_pc", 32'(bus.pc), 32'd0);

    // Random programs with random control and condition traffic
    for (int r = 0; r < 8; r++) begin
      pulseStop();
      for (int a = 0; a < 64; a++) loadWord(a, randWord());
      startRun();
      for (int k = 0; k < 150; k++) begin
        applyStimulus($urandom_range(0, 99) < 4, $urandom_range(0, 99) < 2,
                      $urandom_range(0, 99) < 5, 6'($urandom), randWord(), 8'($urandom));
        @(negedge clk);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 6'd0, 16'd0, 8'd0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
